// File: rtl/lsu_bus_if.sv
// lsu_bus_if: load/store unit sitting between the single-cycle datapath and a
// valid/ready data-memory bus.
//
// Each aligned load or store from the datapath becomes one bus transaction.
// The core is held through `stall` while the transaction is outstanding. For a
// load, the addressed lane of the returned word is sign- or zero-extended and
// returned on `read_data`, which feeds the result mux.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   mem_read, mem_write   decoder memory controls (mutually exclusive)
//   funct3                access size/sign (lb/lh/lw/lbu/lhu, sb/sh/sw)
//   addr, store_data      ALU byte address and rs2 value
//   read_data             extended load result (held until the next load)
//   stall                 freeze PC/regfile while high
//   misaligned            access not aligned to its size (op is not issued)
//   bus_err               one-cycle pulse when a transaction times out
//   bus_req/we/addr/be/wdata  request channel, stable until bus_ready
//   bus_ready             request accepted (qualified by bus_req)
//   bus_rvalid, bus_rdata read response channel
module lsu_bus_if #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      sdata_q, sdata_d;
  logic             we_q, we_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             bus_err_q, bus_err_d;

  logic        mem_op;
  logic        expired;
  logic [31:0] lane_word;
  logic [31:0] load_ext;
  logic [3:0]  be_enc;
  logic [31:0] wdata_enc;

  // Alignment check on the live instruction; only meaningful for memory ops.
  always_comb begin
    mem_op = mem_read | mem_write;
    unique case (funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = mem_op & addr[0];
      default: misaligned = mem_op & (addr[1:0] != 2'b00);
    endcase
  end

  // The counter keeps running from REQ into RESP, so the budget covers both
  // phases together. Using >= lets a load granted on the very last REQ cycle
  // still expire on its first RESP cycle instead of wrapping.
  assign expired = (cnt_q >= CNT_LAST);

  // Lane extraction from the latched address. Halves are always 2-byte
  // aligned here, so the same byte shift serves both sizes.
  always_comb begin
    lane_word = bus_rdata >> {addr_q[1:0], 3'b000};
    unique case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & lane_word[7]}},  lane_word[7:0]};
      2'b01:   load_ext = {{16{~funct3_q[2] & lane_word[15]}}, lane_word[15:0]};
      default: load_ext = bus_rdata;
    endcase
  end

  // Store lane encoding from the latched request.
  always_comb begin
    unique case (funct3_q[1:0])
      2'b00: begin
        be_enc    = 4'b0001 << addr_q[1:0];
        wdata_enc = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        be_enc    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_enc = {2{sdata_q[15:0]}};
      end
      default: begin
        be_enc    = 4'b1111;
        wdata_enc = sdata_q;
      end
    endcase
  end

  // State register and latched request/response state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      funct3_q    <= '0;
      sdata_q     <= '0;
      we_q        <= 1'b0;
      read_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      sdata_q     <= sdata_d;
      we_q        <= we_d;
      read_data_q <= read_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    sdata_d     = sdata_q;
    we_d        = we_q;
    read_data_d = read_data_q;
    bus_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op && !misaligned) begin
          state_d  = REQ;
          cnt_d    = '0;
          addr_d   = addr;
          funct3_d = funct3;
          sdata_d  = store_data;
          we_d     = mem_write;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A grant beats expiry; rvalid in the grant cycle is not looked at.
        if (bus_ready) begin
          state_d = we_q ? DONE : RESP;
        end else if (expired) begin
          state_d     = DONE;
          bus_err_d   = 1'b1;
          read_data_d = '0;
        end
      end
      RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rvalid) begin
          state_d     = DONE;
          read_data_d = load_ext;
        end else if (expired) begin
          state_d     = DONE;
          bus_err_d   = 1'b1;
          read_data_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    bus_req   = (state_q == REQ);
    bus_we    = bus_req & we_q;
    bus_be    = bus_we ? be_enc : 4'b0000;
    bus_addr  = {addr_q[31:2], 2'b00};
    bus_wdata = wdata_enc;
    read_data = read_data_q;
    bus_err   = bus_err_q;
    // Stall starts combinationally in IDLE so the core freezes on the very
    // cycle the op is presented; it drops in DONE so the core commits then.
    stall     = (mem_op & ~misaligned & (state_q == IDLE)) |
                (state_q == REQ) | (state_q == RESP);
  end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Self-checking bench for lsu_bus_if. Every transaction's cycle-by-cycle
// expectations are derived from its schedule (grant cycle, response cycle,
// shared timeout budget); a negedge compare process checks the DUT against
// them. Directed cases pin the model with literal values.
module tb_lsu_bus_if;

  localparam int T = 16;

  logic        clk;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [31:0] read_data;
  logic        stall, misaligned, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;

  lsu_bus_if #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .read_data  (read_data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int op_num = 0;

  // Expectations for the current cycle.
  logic        exp_valid = 1'b0;
  logic        exp_stall, exp_mis, exp_req, exp_err, exp_we, exp_wchk;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata, exp_rd;
  logic [31:0] model_rd = 32'h0;

  // Observations gathered by the compare process.
  int          stall_seen = 0;
  int          err_seen = 0;
  int          mis_seen = 0;
  int          req_seen = 0;
  logic [3:0]  last_be;
  logic [31:0] last_addr, last_wdata;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endfunction

  // Reference arithmetic for the bus lanes and load extension.
  function automatic logic [31:0] m_load(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
    logic [31:0] sh;
    logic [31:0] v;
    sh = w >> (8 * off);
    if (f3[1:0] == 2'b00) begin
      v = sh & 32'hFF;
      if (!f3[2] && v >= 32'd128) v = v - 32'd256;
    end else if (f3[1:0] == 2'b01) begin
      v = sh & 32'hFFFF;
      if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(logic st, logic [2:0] f3, logic [1:0] off);
    if (!st) return 4'b0000;
    if (f3[1:0] == 2'b00) return 4'b0001 << off;
    if (f3[1:0] == 2'b01) return 4'b0011 << (off & 2'b10);
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] sd);
    if (f3[1:0] == 2'b00) return {24'h0, sd[7:0]} * 32'h01010101;
    if (f3[1:0] == 2'b01) return {16'h0, sd[15:0]} * 32'h00010001;
    return sd;
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("stall", {31'h0, stall}, {31'h0, exp_stall});
      chk("misaligned", {31'h0, misaligned}, {31'h0, exp_mis});
      chk("bus_req", {31'h0, bus_req}, {31'h0, exp_req});
      chk("bus_err", {31'h0, bus_err}, {31'h0, exp_err});
      chk("read_data", read_data, exp_rd);
      if (exp_req) begin
        chk("bus_we", {31'h0, bus_we}, {31'h0, exp_we});
        chk("bus_be", {28'h0, bus_be}, {28'h0, exp_be});
        chk("bus_addr", bus_addr, exp_addr);
        if (exp_wchk) chk("bus_wdata", bus_wdata, exp_wdata);
      end
    end
    if (stall) stall_seen++;
    if (bus_err) err_seen++;
    if (misaligned) mis_seen++;
    if (bus_req) begin
      req_seen++;
      last_be    = bus_be;
      last_addr  = bus_addr;
      last_wdata = bus_wdata;
    end
  end

  // One aligned transaction. rd = index of the REQ cycle carrying bus_ready,
  // rv = index of the RESP cycle carrying bus_rvalid. Timing follows the
  // rules: REQ and RESP share a budget of T cycles; completion on the last
  // budget cycle wins over the timeout. Called at posedge+1 with DUT in IDLE.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input int rd, input int rv,
                       input logic [31:0] rdata);
    int  nreq, nresp, je, total;
    logic granted, to;
    if (rd <= T - 1) begin nreq = rd + 1; granted = 1'b1; end
    else             begin nreq = T;      granted = 1'b0; end
    if (!st && granted) begin
      je = (T - 1 - nreq > 0) ? (T - 1 - nreq) : 0;
      if (rv <= je) begin nresp = rv + 1; to = 1'b0; end
      else          begin nresp = je + 1; to = 1'b1; end
    end else begin
      nresp = 0;
      to    = !granted;
    end
    total = nreq + nresp + 2;
    op_num++;
    mem_read   = !st;
    mem_write  = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    for (int c = 0; c < total; c++) begin
      exp_valid  = 1'b1;
      exp_stall  = 1'b1;
      exp_mis    = 1'b0;
      exp_req    = 1'b0;
      exp_err    = 1'b0;
      exp_rd     = model_rd;
      bus_ready  = 1'($urandom_range(0, 1));
      bus_rvalid = 1'($urandom_range(0, 1));
      bus_rdata  = $urandom;
      if (c >= 1 && c <= nreq) begin
        exp_req   = 1'b1;
        exp_we    = st;
        exp_be    = m_be(st, f3, a[1:0]);
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_wchk  = st;
        exp_wdata = m_wdata(f3, sd);
        bus_ready = (c - 1 == rd);
      end else if (c > nreq && c <= nreq + nresp) begin
        bus_rvalid = (c - 1 - nreq == rv);
        if (bus_rvalid) bus_rdata = rdata;
      end else if (c == total - 1) begin
        exp_stall = 1'b0;
        exp_err   = to;
        if (to)       model_rd = 32'h0;
        else if (!st) model_rd = m_load(f3, a[1:0], rdata);
        exp_rd = model_rd;
      end
      @(posedge clk);
      #1;
    end
    $display("txn %0d %s f3=%0d addr=%h ready@%0d rvalid@%0d timeout=%0b read_data=%h",
             op_num, st ? "store" : "load", f3, a, rd, rv, to, model_rd);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      funct3     = 3'($urandom);
      addr       = $urandom & 32'hFFFF_FFFC;
      store_data = $urandom;
      bus_ready  = 1'($urandom_range(0, 1));
      bus_rvalid = 1'($urandom_range(0, 1));
      bus_rdata  = $urandom;
      exp_valid  = 1'b1;
      exp_stall  = 1'b0;
      exp_mis    = 1'b0;
      exp_req    = 1'b0;
      exp_err    = 1'b0;
      exp_rd     = model_rd;
      @(posedge clk);
      #1;
    end
  endtask

  // A misaligned op held for two cycles: it must never be issued.
  task automatic mis_op(input logic st, input logic [2:0] f3, input logic [31:0] a);
    op_num++;
    for (int k = 0; k < 2; k++) begin
      mem_read   = !st;
      mem_write  = st;
      funct3     = f3;
      addr       = a;
      store_data = $urandom;
      bus_ready  = 1'($urandom_range(0, 1));
      bus_rvalid = 1'($urandom_range(0, 1));
      bus_rdata  = $urandom;
      exp_valid  = 1'b1;
      exp_stall  = 1'b0;
      exp_mis    = 1'b1;
      exp_req    = 1'b0;
      exp_err    = 1'b0;
      exp_rd     = model_rd;
      @(posedge clk);
      #1;
    end
    $display("txn %0d misaligned %s f3=%0d addr=%h", op_num, st ? "store" : "load", f3, a);
  endtask

  initial begin
    int s0, e0, m0, r0;
    logic st;
    logic [2:0] f3;
    logic [31:0] a;
    int rd, rv;

    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    #3;
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
    chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
    chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // lw 0x100: grant on first REQ cycle, rvalid two cycles later.
    s0 = stall_seen;
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
    chk("lw_rdata", read_data, 32'hDEADBEEF);
    chk("lw_stall_cycles", stall_seen - s0, 4);
    chk("lw_be", {28'h0, last_be}, 32'h0);
    idle(1);

    // sb 0x203 with three wait cycles before the grant.
    s0 = stall_seen;
    do_op(1'b1, 3'b000, 32'h203, 32'h0000_00A5, 3, 0, 32'h0);
    chk("sb_addr", last_addr, 32'h200);
    chk("sb_be", {28'h0, last_be}, 32'h8);
    chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
    chk("sb_stall_cycles", stall_seen - s0, 5);
    chk("sb_rdata_held", read_data, 32'hDEADBEEF);

    // Back-to-back extension cases.
    do_op(1'b0, 3'b000, 32'h1, 32'h0, 0, 0, 32'h0000_8000);
    chk("lb_rdata", read_data, 32'hFFFFFF80);
    do_op(1'b0, 3'b100, 32'h1, 32'h0, 0, 0, 32'h0000_8000);
    chk("lbu_rdata", read_data, 32'h00000080);
    do_op(1'b0, 3'b001, 32'h2, 32'h0, 0, 0, 32'h8001_0000);
    chk("lh_rdata", read_data, 32'hFFFF8001);
    idle(1);

    // Misaligned word load and half store.
    m0 = mis_seen; r0 = req_seen;
    mis_op(1'b0, 3'b010, 32'h102);
    mis_op(1'b1, 3'b001, 32'h101);
    chk("mis_cycles", mis_seen - m0, 4);
    chk("mis_no_req", req_seen - r0, 0);
    chk("mis_rdata_held", read_data, 32'hFFFF8001);
    idle(1);

    // Load whose request is never accepted.
    s0 = stall_seen; e0 = err_seen;
    do_op(1'b0, 3'b010, 32'h300, 32'h0, 1000, 0, 32'h0);
    chk("to_err_pulses", err_seen - e0, 1);
    chk("to_stall_cycles", stall_seen - s0, T + 1);
    chk("to_rdata", read_data, 32'h0);
    do_op(1'b0, 3'b010, 32'h104, 32'h0, 1, 0, 32'h11223344);
    chk("after_to_rdata", read_data, 32'h11223344);

    // Reset while waiting in RESP, then a stale rvalid.
    exp_valid = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h40;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(posedge clk); #1;
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid_pre_stall", {31'h0, stall}, 32'h1);
    chk("rst_mid_pre_rdata", read_data, 32'h11223344);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_req", {31'h0, bus_req}, 32'h0);
    chk("rst_mid_rdata", read_data, 32'h0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk);
    chk("stale_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("stale_rdata", read_data, 32'h0);
    chk("stale_req", {31'h0, bus_req}, 32'h0);
    chk("stale_err", {31'h0, bus_err}, 32'h0);
    model_rd = 32'h0;
    @(posedge clk); #1;
    $display("txn %0d reset during RESP, stale rvalid ignored", ++op_num);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        f3 = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010;
        a  = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        if (f3 == 3'b001) a[0] = 1'b1;
        if (!st && $urandom_range(0, 1) == 1) f3[2] = (f3 == 3'b001);
        mis_op(st, f3, a);
        idle(1);
      end else begin
        if (st) f3 = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end
        a = $urandom;
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
        rd = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 3);
        rv = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 18) : $urandom_range(0, 3);
        do_op(st, f3, a, $urandom, rd, rv, $urandom);
        idle($urandom_range(0, 2));
      end
    end

    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
